// File: rtl/score_keeper.sv
// Game-score tracker: counts eat events per round, saturates at MAX_SCORE, runs IDLE/PLAY/OVER FSM.
// Latency: all outputs registered; live updates one edge after an eat rising edge, score on frame_tick.
// Backpressure: none; inputs are pulses sampled every cycle. Optional high score via SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper #(
    parameter int unsigned MAX_SCORE = 99,
    parameter int unsigned POINTS    = 1
) (
    input  logic       VGA_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       eat,
    input  logic       collide,
    input  logic       frame_tick,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       new_high,
    output logic [1:0] state,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t     state_q;
    state_t     state_nxt;
    logic [7:0] live;
    logic [7:0] live_nxt;
    logic [7:0] score_nxt;
    logic       eat_d;
    logic       eat_evt;
    logic [8:0] sum;
    logic [7:0] inc_val;

    // Rising-edge detect so a held eat counts once; 9-bit sum cannot wrap before the clamp.
    always_comb begin
        eat_evt = eat & ~eat_d;
        sum     = {1'b0, live} + 9'(POINTS);
        inc_val = (sum > 9'(MAX_SCORE)) ? 8'(MAX_SCORE) : sum[7:0];
    end

    // Next-state and running-count logic; start overrides eat/collide in every state.
    always_comb begin
        state_nxt = state_q;
        live_nxt  = live;
        case (state_q)
            IDLE: begin
                live_nxt = 8'd0;
                if (start) state_nxt = PLAY;
            end
            PLAY: begin
                if (start) begin
                    live_nxt = 8'd0;
                end else begin
                    if (eat_evt) live_nxt = inc_val;
                    if (collide) state_nxt = OVER;
                end
            end
            OVER: begin
                if (start) begin
                    state_nxt = PLAY;
                    live_nxt  = 8'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                live_nxt  = 8'd0;
            end
        endcase
    end

    // Display shadow: cleared by start, otherwise samples pre-increment live on frame_tick.
    always_comb begin
        score_nxt = score;
        if (start)
            score_nxt = 8'd0;
        else if (frame_tick)
            score_nxt = live;
    end

    // State, count, edge-detect history and display registers.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            live      <= 8'd0;
            eat_d     <= 1'b0;
            score     <= 8'd0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            live      <= live_nxt;
            eat_d     <= eat;
            score     <= score_nxt;
            game_over <= (state_nxt == OVER);
        end
    end

    assign state = state_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    logic round_end;

    // Only the PLAY->OVER transition can post a new best; the comparison uses the post-eat value.
    always_comb begin
        round_end = (state_q == PLAY) && (state_nxt == OVER);
    end

    // High score survives start; only reset clears it. new_high is a one-cycle pulse.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            high_score <= 8'd0;
            new_high   <= 1'b0;
        end else begin
            new_high <= 1'b0;
            if (round_end && (live_nxt > high_score)) begin
                high_score <= live_nxt;
                new_high   <= 1'b1;
            end
        end
    end
`else
    assign high_score = 8'd0;
    assign new_high   = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: counting, edge detect, saturation, FSM, high score, async reset.
// A second instance with POINTS=10 shares the stimulus and is checked at the saturation step.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_score_keeper;

    logic       VGA_clk = 1'b0;
    logic       rst_n;
    logic       start, eat, collide, frame_tick;
    logic [7:0] score, high_score, score2, high_score2;
    logic       new_high, game_over, new_high2, game_over2;
    logic [1:0] state, state2;

    int errors = 0;
    int checks = 0;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    localparam logic [7:0] HS_EXP = 8'd8;
    localparam logic       NH_EXP = 1'b1;
`else
    localparam logic [7:0] HS_EXP = 8'd0;
    localparam logic       NH_EXP = 1'b0;
`endif

    score_keeper dut (
        .VGA_clk(VGA_clk), .rst_n(rst_n), .start(start), .eat(eat),
        .collide(collide), .frame_tick(frame_tick), .score(score),
        .high_score(high_score), .new_high(new_high), .state(state),
        .game_over(game_over)
    );

    score_keeper #(.MAX_SCORE(99), .POINTS(10)) dut10 (
        .VGA_clk(VGA_clk), .rst_n(rst_n), .start(start), .eat(eat),
        .collide(collide), .frame_tick(frame_tick), .score(score2),
        .high_score(high_score2), .new_high(new_high2), .state(state2),
        .game_over(game_over2)
    );

    always #5 VGA_clk = ~VGA_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge VGA_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic eat_pulse();
        eat = 1'b1; tick(); eat = 1'b0; tick();
    endtask

    task automatic frame();
        frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_score"},      score,              8'd0);
        chk({tag, "_high_score"}, high_score,         8'd0);
        chk({tag, "_new_high"},   {7'd0, new_high},   8'd0);
        chk({tag, "_state"},      {6'd0, state},      8'd0);
        chk({tag, "_game_over"},  {7'd0, game_over},  8'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; eat = 1'b0; collide = 1'b0; frame_tick = 1'b0;
        #12;
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Round 1: five separate eats, then a frame tick.
        pulse_start();
        chk("start_state", {6'd0, state}, 8'd1);
        chk("start_score", score, 8'd0);
        repeat (5) eat_pulse();
        frame();
        chk("five_eats_score", score, 8'd5);
        chk("five_eats_state", {6'd0, state}, 8'd1);
        chk("five_eats_score_p10", score2, 8'd50);

        // Restart in PLAY, then eat held high for 20 cycles counts once.
        pulse_start();
        chk("restart_score", score, 8'd0);
        chk("restart_state", {6'd0, state}, 8'd1);
        eat = 1'b1;
        repeat (20) tick();
        eat = 1'b0;
        tick();
        frame();
        chk("held_eat_score", score, 8'd1);

        // Eat coincident with frame_tick at live=4 shows pre-increment value.
        repeat (3) eat_pulse();
        eat = 1'b1; frame_tick = 1'b1;
        tick();
        eat = 1'b0; frame_tick = 1'b0;
        chk("coincident_score", score, 8'd4);
        tick();
        frame();
        chk("coincident_next_score", score, 8'd5);

        // Saturation: 12 eats on POINTS=10 clamps at 99.
        pulse_start();
        repeat (12) eat_pulse();
        frame();
        chk("sat_score_p10", score2, 8'd99);
        chk("sat_score_p1", score, 8'd12);

        // High score: 7 eats, then 8th eat together with collide.
        pulse_start();
        repeat (7) eat_pulse();
        eat = 1'b1; collide = 1'b1;
        tick();
        eat = 1'b0; collide = 1'b0;
        chk("over_state", {6'd0, state}, 8'd2);
        chk("over_game_over", {7'd0, game_over}, 8'd1);
        chk("over_high_score", high_score, HS_EXP);
        chk("over_new_high", {7'd0, new_high}, {7'd0, NH_EXP});
        tick();
        chk("new_high_one_cycle", {7'd0, new_high}, 8'd0);
        eat_pulse();
        collide = 1'b1; tick(); collide = 1'b0;
        frame();
        chk("over_eat_ignored_score", score, 8'd8);
        chk("over_collide_state", {6'd0, state}, 8'd2);

        // Lower round leaves high score unchanged and gives no pulse.
        pulse_start();
        chk("replay_state", {6'd0, state}, 8'd1);
        chk("replay_game_over", {7'd0, game_over}, 8'd0);
        chk("replay_high_kept", high_score, HS_EXP);
        repeat (3) eat_pulse();
        collide = 1'b1;
        tick();
        collide = 1'b0;
        chk("low_round_state", {6'd0, state}, 8'd2);
        chk("low_round_new_high", {7'd0, new_high}, 8'd0);
        chk("low_round_high", high_score, HS_EXP);

        // Asynchronous reset mid-round at score 6.
        pulse_start();
        repeat (6) eat_pulse();
        frame();
        chk("pre_reset_score", score, 8'd6);
        rst_n = 1'b0;
        #2;
        chk_reset("async_reset");
        #1;
        rst_n = 1'b1;
        tick();

        // eat and collide are ignored in IDLE.
        eat_pulse();
        collide = 1'b1; tick(); collide = 1'b0;
        frame();
        chk("idle_state", {6'd0, state}, 8'd0);
        chk("idle_game_over", {7'd0, game_over}, 8'd0);
        chk("idle_score", score, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
